// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its monitor:
// phase codes, 7-segment digit patterns and monitor state encoding.
package traffic_pkg;

   typedef enum logic [1:0] {
      PH_RED     = 2'd0,
      PH_GREEN   = 2'd1,
      PH_YELLOW  = 2'd2,
      PH_INVALID = 2'd3
   } phase_e;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } mon_state_e;

   // Segment order {g,f,e,d,c,b,a}; the decimal point is kept outside.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic phase_e next_phase(input phase_e p);
      case (p)
         PH_RED:    return PH_GREEN;
         PH_GREEN:  return PH_YELLOW;
         PH_YELLOW: return PH_RED;
         default:   return PH_INVALID;
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_monitor_seg7_decode.sv
// Combinational 7-segment pattern decoder; the blank pattern is accepted
// as zero only when blank_ok is set (leading-zero suppression on tens).
module seg7_decode
   import traffic_pkg::*;
(
   input  logic [7:0] pattern,
   input  logic       blank_ok,
   output logic [3:0] digit,
   output logic       valid
);

   logic unused_dp;
   assign unused_dp = pattern[7];

   always_comb begin
      digit = 4'd0;
      valid = 1'b1;
      case (pattern[6:0])
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         SEG_BLANK: valid = blank_ok;
         default:   valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive protocol checker for the traffic-light controller outputs:
// decodes lamps and display digits, tracks phase/countdown, flags violations.
module traffic_light_monitor
   import traffic_pkg::*;
#(
   parameter int STALL_LIMIT = 100000000,
   parameter int CNT_W       = 27
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        red,
   input  logic        yellow,
   input  logic        green,
   input  logic [7:0]  led0,
   input  logic [7:0]  led1,
   output logic [1:0]  phase,
   output logic [5:0]  count,
   output logic        locked,
   output logic        err_light,
   output logic        err_seg,
   output logic        err_seq,
   output logic        err_count,
   output logic        err_stall,
   output logic [5:0]  last_len,
   output logic [15:0] cycles
);

   logic             red_q, yellow_q, green_q;
   logic [7:0]       led0_q, led1_q;
   phase_e           phase_q, phase_d;
   logic [5:0]       count_q, count_d;
   mon_state_e       state_q, state_d;
   logic             locked_q, locked_d;
   logic             err_light_q, err_light_d;
   logic             err_seg_q, err_seg_d;
   logic             err_seq_q, err_seq_d;
   logic             err_count_q, err_count_d;
   logic             err_stall_q, err_stall_d;
   logic [5:0]       last_len_q, last_len_d;
   logic [15:0]      cycles_q, cycles_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic [3:0] units_dig, tens_dig;
   logic       units_ok, tens_ok;
   logic [6:0] seg_sum;
   phase_e     dec_phase;
   logic       light_ok, seg_ok;
   logic [5:0] dec_count;
   logic       evt;
   logic       f_light, f_seg, f_seq, f_count;

   seg7_decode u_units (
      .pattern  (led0_q),
      .blank_ok (1'b0),
      .digit    (units_dig),
      .valid    (units_ok)
   );

   seg7_decode u_tens (
      .pattern  (led1_q),
      .blank_ok (1'b1),
      .digit    (tens_dig),
      .valid    (tens_ok)
   );

   always_comb begin
      dec_phase = PH_INVALID;
      light_ok  = 1'b1;
      case ({red_q, yellow_q, green_q})
         3'b100:  dec_phase = PH_RED;
         3'b001:  dec_phase = PH_GREEN;
         3'b010:  dec_phase = PH_YELLOW;
         default: light_ok  = 1'b0;
      endcase
   end

   assign seg_sum   = {3'd0, tens_dig} * 7'd10 + {3'd0, units_dig};
   assign seg_ok    = units_ok && tens_ok && (seg_sum <= 7'd63);
   assign dec_count = seg_ok ? seg_sum[5:0] : 6'd0;
   assign evt       = (dec_phase != phase_q) || (dec_count != count_q);

   always_comb begin
      phase_d     = dec_phase;
      count_d     = dec_count;
      state_d     = state_q;
      err_light_d = err_light_q;
      err_seg_d   = err_seg_q;
      err_seq_d   = err_seq_q;
      err_count_d = err_count_q;
      err_stall_d = err_stall_q;
      last_len_d  = last_len_q;
      cycles_d    = cycles_q;
      stall_d     = '0;
      f_light     = 1'b0;
      f_seg       = 1'b0;
      f_seq       = 1'b0;
      f_count     = 1'b0;

      if (clear) begin
         state_d     = ST_SYNC;
         err_light_d = 1'b0;
         err_seg_d   = 1'b0;
         err_seq_d   = 1'b0;
         err_count_d = 1'b0;
         err_stall_d = 1'b0;
      end else begin
         case (state_q)
            ST_SYNC: begin
               if (light_ok && seg_ok) state_d = ST_TRACK;
            end
            ST_TRACK: begin
               if (evt) begin
                  f_light = !light_ok;
                  f_seg   = !seg_ok;
                  // Ordering checks only make sense on a fully decodable tuple.
                  if (light_ok && seg_ok) begin
                     if (dec_phase == phase_q) begin
                        f_count = !((count_q != 6'd0) && (dec_count == count_q - 6'd1));
                     end else begin
                        f_seq   = (dec_phase != next_phase(phase_q));
                        f_count = !((count_q == 6'd0) && (dec_count != 6'd0));
                        if (!f_seq && !f_count) begin
                           last_len_d = dec_count;
                           if (phase_q == PH_YELLOW) cycles_d = cycles_q + 16'd1;
                        end
                     end
                  end
                  err_light_d = err_light_q | f_light;
                  err_seg_d   = err_seg_q   | f_seg;
                  err_seq_d   = err_seq_q   | f_seq;
                  err_count_d = err_count_q | f_count;
                  if (f_light || f_seg || f_seq || f_count) state_d = ST_FAULT;
               end else begin
                  stall_d = stall_q + CNT_W'(1);
                  if (stall_d == CNT_W'(STALL_LIMIT)) begin
                     err_stall_d = 1'b1;
                     state_d     = ST_FAULT;
                  end
               end
            end
            default: state_d = ST_FAULT;
         endcase
      end

      locked_d = (state_d == ST_TRACK);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         red_q       <= 1'b0;
         yellow_q    <= 1'b0;
         green_q     <= 1'b0;
         led0_q      <= 8'h00;
         led1_q      <= 8'h00;
         phase_q     <= PH_INVALID;
         count_q     <= 6'd0;
         state_q     <= ST_SYNC;
         locked_q    <= 1'b0;
         err_light_q <= 1'b0;
         err_seg_q   <= 1'b0;
         err_seq_q   <= 1'b0;
         err_count_q <= 1'b0;
         err_stall_q <= 1'b0;
         last_len_q  <= 6'd0;
         cycles_q    <= 16'd0;
         stall_q     <= '0;
      end else begin
         red_q       <= red;
         yellow_q    <= yellow;
         green_q     <= green;
         led0_q      <= led0;
         led1_q      <= led1;
         phase_q     <= phase_d;
         count_q     <= count_d;
         state_q     <= state_d;
         locked_q    <= locked_d;
         err_light_q <= err_light_d;
         err_seg_q   <= err_seg_d;
         err_seq_q   <= err_seq_d;
         err_count_q <= err_count_d;
         err_stall_q <= err_stall_d;
         last_len_q  <= last_len_d;
         cycles_q    <= cycles_d;
         stall_q     <= stall_d;
      end
   end

   assign phase     = phase_q;
   assign count     = count_q;
   assign locked    = locked_q;
   assign err_light = err_light_q;
   assign err_seg   = err_seg_q;
   assign err_seq   = err_seq_q;
   assign err_count = err_count_q;
   assign err_stall = err_stall_q;
   assign last_len  = last_len_q;
   assign cycles    = cycles_q;

endmodule
